divide_seq: RTL and testbench

DIVIDE_SEQ -- requirements
Module: divide_seq

---
 rtl/divide_seq.sv | 147 ++++++++++++++
 tb/tb_divide_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/divide_seq.sv
// divide_seq: sequential restoring radix-2 divider with valid/ready handshakes.
// One quotient bit per cycle on operand magnitudes. A FIX cycle applies the sign
// correction, and results are held in DONE until the consumer takes them.
module divide_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] abus,
  input  logic [WIDTH-1:0] bbus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic             dz
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  // Dividend magnitude shifts out of the MSB while quotient bits shift into the LSB.
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0]   r_part;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_rem;
  logic             r_dz;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_take;
  logic             w_bzero;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH+1:0] w_trial;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_take   = r_out_valid && out_ready;
  assign w_bzero  = (bbus == '0);
  assign w_a_neg  = SIGNED && abus[WIDTH-1];
  assign w_b_neg  = SIGNED && bbus[WIDTH-1];
  assign w_a_mag  = w_a_neg ? ('0 - abus) : abus;
  assign w_b_mag  = w_b_neg ? ('0 - bbus) : bbus;

  // The trial value is always below 2^(WIDTH+1), so the top bit of the difference is the borrow.
  assign w_trial  = {r_part, r_dvd[WIDTH-1]};
  assign w_diff   = w_trial - {2'b00, r_dvs};
  assign w_ge     = ~w_diff[WIDTH+1];

  assign w_q_fix  = r_neg_q ? ('0 - r_dvd) : r_dvd;
  assign w_r_fix  = r_neg_r ? ('0 - r_part[WIDTH-1:0]) : r_part[WIDTH-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_state_nxt = w_bzero ? DONE : CALC;
      CALC: if (r_cnt == CW'(1)) w_state_nxt = FIX;
      FIX:  w_state_nxt = DONE;
      DONE: if (w_take) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state and the registered valid flag.
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = r_out_valid;
  end

  assign out = r_out;
  assign rem = r_rem;
  assign dz  = r_dz;

  // Operand capture and the restoring iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_part  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= CW'(WIDTH);
      r_dvd   <= w_a_mag;
      r_dvs   <= w_b_mag;
      r_part  <= '0;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end else if (r_state == CALC) begin
      r_cnt   <= r_cnt - CW'(1);
      r_dvd   <= {r_dvd[WIDTH-2:0], w_ge};
      r_part  <= w_ge ? w_diff[WIDTH:0] : w_trial[WIDTH:0];
    end
  end

  // Result registers: loaded at a divide-by-zero accept or when FIX completes; held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
      r_rem <= '0;
      r_dz  <= 1'b0;
    end else if (w_accept && w_bzero) begin
      r_out <= '1;
      r_rem <= abus;
      r_dz  <= 1'b1;
    end else if (r_state == FIX) begin
      r_out <= w_q_fix;
      r_rem <= w_r_fix;
      r_dz  <= 1'b0;
    end
  end

  // Result-valid flag: rises one edge after DONE is entered and drops on the consumer handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_out_valid <= 1'b0;
    else        r_out_valid <= (r_state == DONE) && !w_take;
  end

endmodule

// File: tb/tb_divide_seq.sv
`timescale 1ns/1ps
// tb_divide_seq: scoreboard bench for divide_seq at WIDTH=8 and WIDTH=4, both signedness modes.
module tb_divide_seq;

  typedef struct {
    int         dut;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         acc;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iv   [4];
  logic       ordy [4];
  logic [7:0] ab   [4];
  logic [7:0] bb   [4];
  wire        ird  [4];
  wire        ov   [4];
  wire        dzw  [4];
  wire  [7:0] oq   [4];
  wire  [7:0] orr  [4];

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   last_d = -1;
  bit   stall_rnd = 1'b0;
  logic prev_ov [4];
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dut 0: 8-bit unsigned, 1: 8-bit signed, 2: 4-bit unsigned, 3: 4-bit signed
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned W = (g < 2) ? 8 : 4;
    logic [W-1:0] w_out;
    logic [W-1:0] w_rem;
    divide_seq #(.WIDTH(W), .SIGNED(g % 2 == 1)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (iv[g]),
      .in_ready (ird[g]),
      .abus     (ab[g][W-1:0]),
      .bbus     (bb[g][W-1:0]),
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .out      (w_out),
      .rem      (w_rem),
      .dz       (dzw[g])
    );
    assign oq[g]  = 8'(w_out);
    assign orr[g] = 8'(w_rem);
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic exp_t model(input int d, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int w, mask, ua, ub, sa, sbv;
    w    = (d < 2) ? 8 : 4;
    mask = (1 << w) - 1;
    ua   = int'(a) & mask;
    ub   = int'(b) & mask;
    e.dut = d;
    e.acc = 0;
    if (ub == 0) begin
      e.q = 8'(mask); e.r = 8'(ua); e.dz = 1'b1; e.lat = 1;
    end else begin
      e.dz  = 1'b0;
      e.lat = w + 2;
      if (d % 2 == 0) begin
        e.q = 8'(ua / ub); e.r = 8'(ua % ub);
      end else begin
        sa  = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sbv = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        e.q = 8'((sa / sbv) & mask);
        e.r = 8'((sa % sbv) & mask);
      end
    end
    return e;
  endfunction

  task automatic wait_ready(input int d);
    int n = 0;
    while (!ird[d] && n < 200) begin tick(); n++; end
    if (!ird[d]) chk("in_ready_timeout", 0, 1);
  endtask

  task automatic wait_drain;
    int n = 0;
    while (sb.size() != 0 && n < 400) begin tick(); n++; end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    if (d != last_d) wait_drain();
    last_d = d;
    wait_ready(d);
    ab[d] = a; bb[d] = b; iv[d] = 1'b1;
    e = model(d, a, b);
    e.acc = cyc + 1;
    sb.push_back(e);
    tick();
    iv[d] = 1'b0; ab[d] = 8'($urandom); bb[d] = 8'($urandom);
  endtask

  task automatic stall_test;
    int n = 0;
    wait_drain();
    ordy[0] = 1'b0;
    run_op(0, 8'd9, 8'd3);
    while (!ov[0] && n < 50) begin tick(); n++; end
    chk("stall_valid_timeout", ov[0], 1);
    for (int i = 0; i < 5; i++) begin
      iv[0] = 1'($urandom); ab[0] = 8'($urandom); bb[0] = 8'($urandom);
      tick();
      chk("stall_in_ready", ird[0], 0);
      chk("stall_out_valid", ov[0], 1);
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    tick();
    chk("post_take_out_valid", ov[0], 0);
    chk("post_take_in_ready", ird[0], 1);
  endtask

  task automatic reset_test;
    wait_drain();
    run_op(0, 8'd200, 8'd7);
    repeat (3) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", ird[0], 1);
    chk("async_rst_out_valid", ov[0], 0);
    chk("async_rst_out", oq[0], 0);
    chk("async_rst_rem", orr[0], 0);
    chk("async_rst_dz", dzw[0], 0);
    sb.delete();
    #2 rst_n = 1'b1;
    repeat (20) tick();
    chk("no_valid_after_reset", ov[0], 0);
  endtask

  // Scoreboard monitor: compares every cycle a result is presented, pops on the handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 4; d++) begin
        if (ov[d]) begin
          if (sb.size() == 0 || sb[0].dut != d) begin
            chk("unexpected_out_valid", ov[d], 0);
          end else begin
            if (!prev_ov[d]) chk("latency", cyc - sb[0].acc, sb[0].lat);
            chk("quotient", oq[d], sb[0].q);
            chk("remainder", orr[d], sb[0].r);
            chk("dz", dzw[d], sb[0].dz);
            chk("in_ready_busy", ird[d], 0);
            if (ordy[d]) void'(sb.pop_front());
          end
        end
        prev_ov[d] <= ov[d];
      end
    end else begin
      for (int d = 0; d < 4; d++) prev_ov[d] <= 1'b0;
    end
  end

  initial begin
    forever begin
      tick();
      if (stall_rnd) for (int d = 0; d < 4; d++) ordy[d] = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 4; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b1; ab[d] = '0; bb[d] = '0;
    end
    #1;
    for (int d = 0; d < 4; d++) begin
      chk("reset_in_ready", ird[d], 1);
      chk("reset_out_valid", ov[d], 0);
      chk("reset_out", oq[d], 0);
      chk("reset_rem", orr[d], 0);
      chk("reset_dz", dzw[d], 0);
    end
    #12 rst_n = 1'b1;
    tick();

    run_op(0, 8'd200, 8'd7);
    run_op(0, 8'd55,  8'd0);
    run_op(0, 8'd0,   8'd5);
    run_op(0, 8'd255, 8'd1);
    run_op(0, 8'd255, 8'd255);
    run_op(0, 8'd7,   8'd200);
    run_op(0, 8'd128, 8'd3);
    stall_test();
    reset_test();

    run_op(1, 8'hF9, 8'h02);
    run_op(1, 8'h80, 8'hFF);
    run_op(1, 8'h80, 8'h01);
    run_op(1, 8'h7F, 8'hFF);
    run_op(1, 8'h05, 8'hFE);
    run_op(1, 8'hF9, 8'h00);
    run_op(1, 8'h80, 8'h80);

    stall_rnd = 1'b1;
    repeat (40) run_op(0, 8'($urandom), 8'($urandom));
    repeat (40) run_op(1, 8'($urandom), 8'($urandom));
    for (int d = 2; d < 4; d++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          run_op(d, 8'(a), 8'(b));
    wait_drain();
    stall_rnd = 1'b0;
    for (int d = 0; d < 4; d++) ordy[d] = 1'b1;
    tick();
    chk("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
